// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM state encoding and line-level constants.
// The receiver imports the same package, so the encoding must stay stable.
package serial_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP
    } serial_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [15:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Modulo-CLKS_PER_BIT cycle counter; bit_end_o marks the last cycle of a serial bit.
// clear_i holds the count at zero so a new bit always starts with a full period.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            clear_i,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count_o,
    output logic                            bit_end_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        bit_end_o = (count_q == LAST);
        count_d   = count_q + CNT_W'(1);
        if (clear_i || bit_end_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, LSB-first data, optional
// even parity, stop bit; every bit lasts CLKS_PER_BIT cycles and the line idles high.
module serial_tx
    import serial_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  load,
    output logic                  ready,
    output logic                  tx_out,
    output logic                  done,
    output serial_state_e         dbg_state
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(CLKS_PER_BIT - 2);

    serial_state_e         state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [IDX_W-1:0]      bit_idx_q;
    logic                  parity_q;
    logic                  tx_q;
    logic                  done_q;

    logic [CNT_W-1:0]      baud_count;
    logic                  bit_end;
    logic                  baud_clear;
    logic                  last_data_bit;
    logic                  done_next;

    // The counter is held at zero while idle so START always lasts a full bit.
    assign baud_clear = (state_q == S_IDLE);

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk_i    (clock),
        .rst_ni   (reset),
        .clear_i  (baud_clear),
        .count_o  (baud_count),
        .bit_end_o(bit_end)
    );

    assign shift_d       = shift_q >> 1;
    assign last_data_bit = (bit_idx_q == LAST_IDX);
    // done is registered, so it is set one cycle ahead to land on the bit_end cycle.
    assign done_next     = (baud_count == PRE_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            parity_q  <= 1'b0;
            tx_q      <= STOP_BIT;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    tx_q      <= STOP_BIT;
                    bit_idx_q <= '0;
                    if (load) begin
                        shift_q  <= data_in;
                        parity_q <= even_parity(16'(data_in));
                        tx_q     <= START_BIT;
                        state_q  <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (last_data_bit) begin
                            bit_idx_q <= '0;
                            if (PARITY_EN) begin
                                tx_q    <= parity_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= STOP_BIT;
                                state_q <= S_STOP;
                            end
                        end else begin
                            shift_q   <= shift_d;
                            tx_q      <= shift_d[0];
                            bit_idx_q <= bit_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        tx_q    <= STOP_BIT;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    tx_q <= STOP_BIT;
                    if (done_next) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    tx_q    <= STOP_BIT;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign tx_out    = tx_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance with parity, one without, checked cycle by cycle
// against a frame model built from the frame format rules.
module tb_serial_tx;
    import serial_pkg::*;

    localparam int CPB = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    data_in;
    logic          load;
    logic          ready;
    logic          tx_out;
    logic          done;
    serial_state_e dbg_state;

    logic [7:0]    data_np;
    logic          load_np;
    logic          ready_np;
    logic          tx_np;
    logic          done_np;
    serial_state_e dbg_np;

    // Expected {tx_out, done, ready} for each successive cycle.
    logic [2:0] exp_q[$];
    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .data_in(data_in), .load(load),
        .ready(ready), .tx_out(tx_out), .done(done), .dbg_state(dbg_state)
    );

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
        .clock(clock), .reset(reset), .data_in(data_np), .load(load_np),
        .ready(ready_np), .tx_out(tx_np), .done(done_np), .dbg_state(dbg_np)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_frame(input logic [7:0] d, input bit pe);
        logic lvl[$];
        lvl.push_back(1'b0);
        for (int b = 0; b < 8; b++) lvl.push_back(d[b]);
        if (pe) lvl.push_back(logic'($countones(d) % 2));
        lvl.push_back(1'b1);
        for (int k = 0; k < lvl.size(); k++) begin
            for (int c = 0; c < CPB; c++) begin
                exp_q.push_back({lvl[k], (k == lvl.size() - 1) && (c == CPB - 1), 1'b0});
            end
        end
    endfunction

    function automatic void push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(3'b101);
    endfunction

    function automatic logic [2:0] obs(input bit np);
        return np ? {tx_np, done_np, ready_np} : {tx_out, done, ready};
    endfunction

    task automatic drive(input bit np, input logic l, input logic [7:0] d);
        if (np) begin
            load_np = l;
            data_np = d;
        end else begin
            load = l;
            data_in = d;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            checks++;
            if (obs(0) !== 3'b101 || dbg_state !== S_IDLE)
                $display("FAIL reset_dut cycle %0d: got %b/%0d expected 101/%0d", i, obs(0), dbg_state, S_IDLE);
            else passes++;
            checks++;
            if (obs(1) !== 3'b101 || dbg_np !== S_IDLE)
                $display("FAIL reset_np cycle %0d: got %b/%0d expected 101/%0d", i, obs(1), dbg_np, S_IDLE);
            else passes++;
        end
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (obs(0) !== 3'b101 || obs(1) !== 3'b101)
            $display("FAIL reset_release: got %b %b expected 101 101", obs(0), obs(1));
        else passes++;
    endtask

    task automatic test_single_frame(input logic [7:0] d, input bit np, input string name);
        exp_q.delete();
        push_frame(d, !np);
        push_idle(2);
        drive(np, 1'b1, d);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs(np) !== e)
                $display("FAIL %s cycle %0d: got tx/done/ready=%b expected %b", name, i + 1, obs(np), e);
            else passes++;
            if (i == 0) drive(np, 1'b0, 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_ignored_load();
        exp_q.delete();
        push_frame(8'h00, 1'b1);
        push_idle(3);
        drive(0, 1'b1, 8'h00);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs(0) !== e)
                $display("FAIL ignored_load cycle %0d: got %b expected %b", i + 1, obs(0), e);
            else passes++;
            if (i == 0) drive(0, 1'b0, 8'h00);
            if (i == 12) drive(0, 1'b1, 8'hFF);
            if (i == 30) drive(0, 1'b0, 8'hFF);
        end
    endtask

    task automatic test_back_to_back();
        int first_len;
        exp_q.delete();
        push_frame(8'h3C, 1'b1);
        first_len = exp_q.size();
        push_idle(1);
        push_frame(8'h81, 1'b1);
        push_idle(2);
        drive(0, 1'b1, 8'h3C);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs(0) !== e)
                $display("FAIL back_to_back cycle %0d: got %b expected %b", i + 1, obs(0), e);
            else passes++;
            if (i == 0) drive(0, 1'b1, 8'h81);
            if (i == first_len + 1) drive(0, 1'b0, 8'($urandom_range(0, 255)));
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        exp_q.delete();
        push_frame(d, 1'b1);
        drive(0, 1'b1, d);
        // Cycles 17..20 carry data bit 3; reset is applied during cycle 18.
        for (int i = 0; i < 18; i++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs(0) !== e)
                $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", i + 1, obs(0), e);
            else passes++;
            if (i == 0) drive(0, 1'b0, 8'($urandom_range(0, 255)));
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (obs(0) !== 3'b101 || dbg_state !== S_IDLE)
            $display("FAIL reset_mid_abort: got %b/%0d expected 101/%0d", obs(0), dbg_state, S_IDLE);
        else passes++;
        reset = 1'b1;
        exp_q.delete();
        push_idle(4);
        for (int i = 0; exp_q.size() > 0; i++) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            @(negedge clock);
            checks++;
            if (obs(0) !== e)
                $display("FAIL reset_mid_idle cycle %0d: got %b expected %b", i + 1, obs(0), e);
            else passes++;
        end
        test_single_frame(8'($urandom_range(0, 255)), 1'b0, "reset_mid_next_frame");
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            test_single_frame(8'($urandom_range(0, 255)), 1'b0, "random_parity");
            test_single_frame(8'($urandom_range(0, 255)), 1'b1, "random_noparity");
        end
    endtask

    initial begin
        reset   = 1'b0;
        load    = 1'b1;
        data_in = 8'($urandom_range(0, 255));
        load_np = 1'b1;
        data_np = 8'($urandom_range(0, 255));
        test_reset();
        test_single_frame(8'hA5, 1'b0, "frame_a5");
        test_single_frame(8'h07, 1'b0, "parity_07");
        test_single_frame(8'h07, 1'b1, "noparity_07");
        test_ignored_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
